johnson_dec: RTL and testbench

JOHNSON_DEC -- requirements
Module: johnson_dec

---
 rtl/johnson_dec.sv | 132 +++++++++++++
 tb/tb_johnson_dec.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/johnson_dec.sv
// rtl/johnson_dec.sv - Johnson code decoder with successor-based lock tracking.
// Classifies, decodes and sequence-checks sampled codes; all outputs registered.
module johnson_dec #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic [WIDTH-1:0]           code_in,
  output logic [$clog2(2*WIDTH)-1:0] idx_out,
  output logic                       idx_valid,
  output logic                       illegal,
  output logic                       seq_err,
  output logic                       locked,
  output logic [7:0]                 err_cnt
);
  localparam int IW = $clog2(2*WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(2*WIDTH-1);
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_CNT);

  typedef enum logic {S_UNLOCKED = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_prev_idx, r_idx;
  logic          r_prev_ok, r_idx_valid, r_illegal, r_seq_err;
  logic [7:0]    r_err_cnt;

  logic [IW:0]   w_pop, w_trans;
  logic          w_legal;
  logic [IW-1:0] w_idx, w_succ;
  logic          w_step, w_stall, w_illegal, w_seq_err;

  // A code is a Johnson code exactly when it has at most one adjacent-bit transition.
  always_comb begin
    w_pop   = '0;
    w_trans = '0;
    for (int i = 0; i < WIDTH; i++)
      w_pop = w_pop + (IW+1)'(code_in[i]);
    for (int i = 0; i < WIDTH-1; i++)
      w_trans = w_trans + (IW+1)'(code_in[i] ^ code_in[i+1]);
  end

  assign w_legal = (w_trans <= (IW+1)'(1));

  always_comb begin
    w_idx = '0;
    if (code_in[WIDTH-1])
      w_idx = w_pop[IW-1:0];
    else if (w_pop != '0)
      w_idx = IW'((IW+1)'(2*WIDTH) - w_pop);
  end

  assign w_succ  = (r_prev_idx == LAST_IDX) ? '0 : r_prev_idx + IW'(1);
  assign w_step  = r_prev_ok && (w_idx == w_succ);
  assign w_stall = r_prev_ok && (w_idx == r_prev_idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_UNLOCKED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_illegal   = 1'b0;
    w_seq_err   = 1'b0;
    if (en) begin
      if (!w_legal) begin
        w_illegal   = 1'b1;
        w_state_nxt = S_UNLOCKED;
        w_cnt_nxt   = '0;
      end else if (r_state == S_LOCKED) begin
        if (!w_step && !w_stall) begin
          w_seq_err   = 1'b1;
          w_state_nxt = S_UNLOCKED;
          w_cnt_nxt   = '0;
        end
      end else if (w_step) begin
        if (r_cnt + 4'd1 >= LOCK_TGT) begin
          w_state_nxt = S_LOCKED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end else if (!w_stall) begin
        w_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx       <= '0;
      r_idx_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_prev_idx  <= '0;
      r_prev_ok   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_idx_valid <= en && w_legal;
      r_illegal   <= w_illegal;
      r_seq_err   <= w_seq_err;
      if (en) begin
        if (w_legal) begin
          r_idx      <= w_idx;
          r_prev_idx <= w_idx;
          r_prev_ok  <= 1'b1;
        end else begin
          r_prev_ok  <= 1'b0;
        end
      end
      if ((w_illegal || w_seq_err) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign idx_out   = r_idx;
  assign idx_valid = r_idx_valid;
  assign illegal   = r_illegal;
  assign seq_err   = r_seq_err;
  assign locked    = (r_state == S_LOCKED);
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_johnson_dec.sv
// tb/tb_johnson_dec.sv - randomized and directed bench for johnson_dec (WIDTH=4).
// Reference model decodes by lookup in a generated Johnson sequence table.
module tb_johnson_dec;
  localparam int W  = 4;
  localparam int N  = 2*W;
  localparam int LC = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [3:0] code_in;
  logic [2:0] idx_out;
  logic       idx_valid, illegal, seq_err, locked;
  logic [7:0] err_cnt;

  johnson_dec #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk(clk), .rstn(rstn), .en(en), .code_in(code_in),
    .idx_out(idx_out), .idx_valid(idx_valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic       v, ill, se, lk;
    logic [7:0] ec;
    logic [3:0] steps;
    logic [2:0] prev;
    logic       pok;
  } ms_t;

  logic [3:0] jtab [N];
  ms_t        m;
  logic       cmp_on = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int find(input logic [3:0] c);
    int pos = -1;
    for (int k = 0; k < N; k++) if (jtab[k] == c) pos = k;
    return pos;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic ms_t mstep(input ms_t s, input logic e, input logic [3:0] c);
    ms_t r;
    int  pos;
    logic succ, stall;
    r = s; r.v = 0; r.ill = 0; r.se = 0;
    if (!e) return r;
    pos = find(c);
    if (pos < 0) begin
      r.ill = 1; r.lk = 0; r.steps = 0; r.pok = 0; r.ec = sat_inc(s.ec);
    end else begin
      r.v = 1; r.idx = 3'(pos);
      succ  = s.pok && (pos == (int'(s.prev) + 1) % N);
      stall = s.pok && (pos == int'(s.prev));
      if (s.lk) begin
        if (!succ && !stall) begin
          r.se = 1; r.lk = 0; r.steps = 0; r.ec = sat_inc(s.ec);
        end
      end else if (succ) begin
        if (int'(s.steps) + 1 >= LC) begin r.lk = 1; r.steps = 0; end
        else r.steps = s.steps + 4'd1;
      end else if (!stall) begin
        r.steps = 0;
      end
      r.prev = 3'(pos); r.pok = 1;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m <= '0;
    else       m <= mstep(m, en, code_in);
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_idx_out",   32'(idx_out),   32'(m.idx));
      chk("m_idx_valid", 32'(idx_valid), 32'(m.v));
      chk("m_illegal",   32'(illegal),   32'(m.ill));
      chk("m_seq_err",   32'(seq_err),   32'(m.se));
      chk("m_locked",    32'(locked),    32'(m.lk));
      chk("m_err_cnt",   32'(err_cnt),   32'(m.ec));
    end
  end

  task automatic put(input logic e, input logic [3:0] c);
    en = e; code_in = c;
    @(negedge clk);
  endtask

  function automatic logic [3:0] rand_illegal();
    logic [3:0] c = 4'b1010;
    for (int t = 0; t < 100; t++) begin
      c = 4'($urandom());
      if (find(c) < 0) return c;
    end
    return 4'b1010;
  endfunction

  initial begin
    logic [3:0] cur;
    rstn = 1'b0; en = 1'b0; code_in = '0;
    cur = '0;
    for (int k = 0; k < N; k++) begin
      jtab[k] = cur;
      cur = {~cur[0], cur[3:1]};
    end
    chk("tab_1", 32'(jtab[1]), 32'h8);
    chk("tab_5", 32'(jtab[5]), 32'h7);
    chk("tab_7", 32'(jtab[7]), 32'h1);

    @(negedge clk);
    @(negedge clk);
    chk("rst_idx",    32'(idx_out), 0);
    chk("rst_locked", 32'(locked),  0);
    chk("rst_errcnt", 32'(err_cnt), 0);
    cmp_on = 1'b1;
    rstn = 1'b1;

    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < N; k++) begin
        put(1'b1, jtab[k]);
        chk("seq_idx",  32'(idx_out), 32'(k));
        chk("seq_lock", 32'(locked),  32'(rep > 0 || k >= 2));
      end
    chk("seq_errcnt", 32'(err_cnt), 0);

    put(1'b1, 4'b0000); put(1'b1, 4'b1000); put(1'b1, 4'b1100);
    for (int k = 0; k < 3; k++) put(1'b1, 4'b1110);
    chk("stall_lock",   32'(locked),  1);
    chk("stall_errcnt", 32'(err_cnt), 0);
    chk("stall_idx",    32'(idx_out), 3);
    for (int k = 0; k < 3; k++) put(1'b0, 4'b1010);
    chk("en0_illegal", 32'(illegal),   0);
    chk("en0_valid",   32'(idx_valid), 0);
    chk("en0_idx",     32'(idx_out),   3);

    put(1'b1, 4'b1010);
    chk("ill_pulse",  32'(illegal),   1);
    chk("ill_lock",   32'(locked),    0);
    chk("ill_errcnt", 32'(err_cnt),   1);
    chk("ill_idx",    32'(idx_out),   3);
    chk("ill_valid",  32'(idx_valid), 0);
    put(1'b1, 4'b1111); chk("relock_0", 32'(locked), 0);
    put(1'b1, 4'b0111); chk("relock_1", 32'(locked), 0);
    put(1'b1, 4'b0011); chk("relock_2", 32'(locked), 1);

    put(1'b1, 4'b0001); put(1'b1, 4'b0000); put(1'b1, 4'b1000); put(1'b1, 4'b1100);
    chk("pre_seq_lock", 32'(locked), 1);
    put(1'b1, 4'b1111);
    chk("se_pulse",   32'(seq_err), 1);
    chk("se_illegal", 32'(illegal), 0);
    chk("se_lock",    32'(locked),  0);
    chk("se_errcnt",  32'(err_cnt), 2);
    chk("se_idx",     32'(idx_out), 4);

    for (int k = 0; k < 500; k++) begin
      int sel;
      logic e;
      logic [3:0] c;
      e   = ($urandom_range(0, 99) < 80);
      sel = $urandom_range(0, 9);
      if (sel < 5)      c = jtab[(int'(m.prev) + 1) % N];
      else if (sel < 7) c = jtab[int'(m.prev)];
      else              c = 4'($urandom());
      put(e, c);
    end

    for (int k = 0; k < 300; k++) put(1'b1, rand_illegal());
    chk("sat_errcnt", 32'(err_cnt), 255);

    put(1'b1, 4'b0000); put(1'b1, 4'b1000); put(1'b1, 4'b1100);
    chk("prerst_lock", 32'(locked), 1);
    #3 rstn = 1'b0;
    #1;
    chk("arst_idx",     32'(idx_out),   0);
    chk("arst_valid",   32'(idx_valid), 0);
    chk("arst_illegal", 32'(illegal),   0);
    chk("arst_seqerr",  32'(seq_err),   0);
    chk("arst_locked",  32'(locked),    0);
    chk("arst_errcnt",  32'(err_cnt),   0);
    @(negedge clk);
    rstn = 1'b1;
    put(1'b1, 4'b0001);
    chk("post_idx",    32'(idx_out),   7);
    chk("post_valid",  32'(idx_valid), 1);
    chk("post_seqerr", 32'(seq_err),   0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
